// File: rtl/score_keeper.sv
// score_keeper: score and high-score tracker for a tile-tapping game.
// States IDLE -> PLAY -> OVER. The displayed score is refreshed only on
// frame_sync so the digit renderer never sees a change mid-frame.
// Optional feature macro STREAK_BONUS_EN: every STREAK_LEN-th consecutive
// hit is worth 2 points instead of 1.
module score_keeper #(
  parameter int MAX_SCORE  = 63,
  parameter int STREAK_LEN = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       start,
  input  logic       hit,
  input  logic       miss,
  input  logic       frame_sync,
  output logic [5:0] score,
  output logic [5:0] high_score,
  output logic       game_over,
  output logic       new_record
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam logic [5:0] MAX_S = 6'(MAX_SCORE);

  // Reject configurations the 6-bit score path cannot represent.
  if (MAX_SCORE > 63 || MAX_SCORE < 1 || STREAK_LEN < 1) begin : g_param_check
    $error("score_keeper: MAX_SCORE must be 1..63 and STREAK_LEN >= 1");
  end

  // Saturating add: the live score clamps at MAX_SCORE and never wraps.
  function automatic logic [5:0] sat_add(input logic [5:0] a, input logic [1:0] inc);
    logic [6:0] sum;
    sum = {1'b0, a} + {5'b0, inc};
    if (sum > {1'b0, MAX_S}) return MAX_S;
    return sum[5:0];
  endfunction

  state_t     state_q, state_d;
  logic [5:0] live_q, live_d;
  logic [5:0] high_q, high_d;
  logic [5:0] score_q;
  logic       nr_q, nr_d;
  logic       go_q;
  logic [1:0] inc;

`ifdef STREAK_BONUS_EN
  localparam int SW = (STREAK_LEN > 1) ? $clog2(STREAK_LEN) : 1;
  logic [SW-1:0] streak_q, streak_d;
`endif

  // Next-state and next-value logic for the game FSM.
  always_comb begin
    state_d = state_q;
    live_d  = live_q;
    high_d  = high_q;
    nr_d    = nr_q;
    inc     = 2'd0;
`ifdef STREAK_BONUS_EN
    streak_d = streak_q;
`endif
    case (state_q)
      IDLE, OVER: begin
        if (start) begin
          state_d = PLAY;
          live_d  = 6'd0;
          nr_d    = 1'b0;
`ifdef STREAK_BONUS_EN
          streak_d = '0;
`endif
        end
      end
      PLAY: begin
        // A miss wins over a simultaneous hit: no increment, game ends.
        if (miss) begin
          state_d = OVER;
          if (live_q > high_q) begin
            high_d = live_q;
            nr_d   = 1'b1;
          end
        end else if (hit) begin
          inc = 2'd1;
`ifdef STREAK_BONUS_EN
          // streak_q wraps at STREAK_LEN, so reaching STREAK_LEN-1 means this
          // hit completes a multiple of STREAK_LEN.
          if (streak_q == SW'(STREAK_LEN - 1)) begin
            inc      = 2'd2;
            streak_d = '0;
          end else begin
            streak_d = streak_q + SW'(1);
          end
`endif
          live_d = sat_add(live_q, inc);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset overrides every other input.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      live_q  <= 6'd0;
      high_q  <= 6'd0;
      score_q <= 6'd0;
      nr_q    <= 1'b0;
      go_q    <= 1'b0;
`ifdef STREAK_BONUS_EN
      streak_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      live_q  <= live_d;
      high_q  <= high_d;
      nr_q    <= nr_d;
      go_q    <= (state_d == OVER);
      // Display takes the pre-update live score, so a coincident hit shows next frame.
      if (frame_sync) score_q <= live_q;
`ifdef STREAK_BONUS_EN
      streak_q <= streak_d;
`endif
    end
  end

  assign score      = score_q;
  assign high_score = high_q;
  assign game_over  = go_q;
  assign new_record = nr_q;

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: stimulus pushes expected outputs after
// each checked edge; a monitor pops and compares on the falling edge.
module tb_score_keeper;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0, start = 1'b0, hit = 1'b0, miss = 1'b0, frame_sync = 1'b0;
  logic [5:0] score, high_score;
  logic       game_over, new_record;

  typedef struct {
    string      name;
    logic [5:0] sc;
    logic [5:0] hs;
    logic       go;
    logic       nr;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   vectors = 0;
  int   fails   = 0;

`ifdef STREAK_BONUS_EN
  localparam int         H12 = 11;
  localparam int         H20 = 18;
  localparam logic [5:0] S62 = 6'd63;
  localparam logic [5:0] S8  = 6'd9;
`else
  localparam int         H12 = 12;
  localparam int         H20 = 20;
  localparam logic [5:0] S62 = 6'd62;
  localparam logic [5:0] S8  = 6'd8;
`endif

  score_keeper #(.MAX_SCORE(63), .STREAK_LEN(8)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .hit(hit), .miss(miss),
    .frame_sync(frame_sync), .score(score), .high_score(high_score),
    .game_over(game_over), .new_record(new_record)
  );

  always #5 Clk = ~Clk;

  // Monitor: compare one expectation per falling edge.
  always @(negedge Clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      vectors++;
      if (score !== e.sc || high_score !== e.hs || game_over !== e.go || new_record !== e.nr) begin
        fails++;
        $display("FAIL %s: got score=%0d high=%0d over=%0b rec=%0b, expected score=%0d high=%0d over=%0b rec=%0b",
                 e.name, score, high_score, game_over, new_record, e.sc, e.hs, e.go, e.nr);
      end
    end
  end

  task automatic cyc(input logic r, input logic s, input logic h, input logic m, input logic f);
    @(negedge Clk);
    Reset = r; start = s; hit = h; miss = m; frame_sync = f;
    @(posedge Clk);
    #1;
  endtask

  task automatic hits(input int n);
    repeat (n) cyc(0, 0, 1, 0, 0);
  endtask

  task automatic expect_out(input string nm, input logic [5:0] sc, input logic [5:0] hs,
                            input logic go, input logic nr);
    exp_t x;
    x.name = nm; x.sc = sc; x.hs = hs; x.go = go; x.nr = nr;
    q.push_back(x);
  endtask

  initial begin
    cyc(1, 0, 0, 0, 0);  expect_out("reset", 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 1);  expect_out("idle_hit_ignored", 0, 0, 0, 0);

    cyc(0, 1, 0, 0, 0);
    hits(5);
    cyc(0, 0, 0, 0, 1);  expect_out("five_hits", 5, 0, 0, 0);
    cyc(0, 0, 1, 0, 1);  expect_out("frame_with_hit", 5, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);  expect_out("next_frame", 6, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);  expect_out("hold_no_frame", 6, 0, 0, 0);

    cyc(0, 0, 1, 1, 0);  expect_out("hit_and_miss", 6, 7, 1, 1);
    cyc(0, 0, 0, 0, 1);  expect_out("over_frame", 7, 7, 1, 1);
    cyc(0, 0, 1, 0, 1);  expect_out("over_hit_ignored", 7, 7, 1, 1);

    cyc(0, 1, 0, 0, 0);  expect_out("restart", 7, 7, 0, 0);
    hits(H12);
    cyc(0, 0, 0, 1, 0);  expect_out("record_12", 7, 12, 1, 1);
    cyc(0, 1, 0, 0, 0);
    hits(H12);
    cyc(0, 0, 0, 1, 0);  expect_out("equal_12", 7, 12, 1, 0);
    cyc(0, 0, 0, 0, 1);  expect_out("equal_12_frame", 12, 12, 1, 0);

    cyc(0, 1, 0, 0, 0);
    hits(62);
    cyc(0, 0, 0, 0, 1);  expect_out("live_62", S62, 12, 0, 0);
    hits(3);
    cyc(0, 0, 0, 0, 1);  expect_out("saturate_63", 63, 12, 0, 0);
    cyc(0, 0, 0, 1, 0);  expect_out("record_63", 63, 63, 1, 1);

    cyc(0, 1, 0, 0, 0);
    hits(H20);
    cyc(0, 0, 0, 0, 1);  expect_out("live_20", 20, 63, 0, 0);
    cyc(1, 0, 1, 0, 0);  expect_out("reset_mid_play", 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 1);  expect_out("post_reset_hit", 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);  expect_out("post_reset_frame", 0, 0, 0, 0);

    cyc(0, 1, 0, 0, 0);
    hits(8);
    cyc(0, 0, 0, 0, 1);  expect_out("streak_8", S8, 0, 0, 0);
    cyc(0, 1, 0, 0, 1);  expect_out("start_in_play", S8, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1);  expect_out("after_play_start", S8 + 6'd1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);  expect_out("final_record", S8 + 6'd1, S8 + 6'd1, 1, 1);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge Clk);
    if (q.size() > 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    @(posedge Clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter MAX_SCORE, default 63: saturation ceiling of live score; SHALL be <= 63.
REQ-002 Parameter STREAK_LEN, default 8: consecutive hits per bonus, used only under STREAK_BONUS_EN.
REQ-003 Clk  input  1  system clock; all state SHALL change on its rising edge only.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse that begins a game.
REQ-006 hit  input  1  one-cycle pulse: tile struck correctly.
REQ-007 miss  input  1  one-cycle pulse: tile missed or wrong key; ends the game.
REQ-008 frame_sync  input  1  one-cycle pulse at start of vertical blank.
REQ-009 score  output  6  displayed score for the digit renderer, binary 0..63.
REQ-010 high_score  output  6  best score since reset, binary.
REQ-011 game_over  output  1  high while in OVER state.
REQ-012 new_record  output  1  high in OVER when the last game set a new high score.

Function
REQ-013 FSM states SHALL be IDLE, PLAY, OVER; encoding is free.
REQ-014 IDLE: start SHALL go to PLAY next cycle and clear live score and streak to 0.
REQ-015 PLAY: hit (miss low) SHALL add 1 to live score, saturating at MAX_SCORE, never wrapping.
REQ-016 PLAY: miss SHALL go to OVER next cycle; live score unchanged.
REQ-017 PLAY: hit and miss in same cycle SHALL be treated as miss only; no increment.
REQ-018 PLAY: start SHALL be ignored.
REQ-019 IDLE/OVER: hit and miss SHALL be ignored.
REQ-020 PLAY->OVER transition: if live score > high_score, high_score SHALL load live score and new_record SHALL go high, both on the same edge as entry to OVER; equal score SHALL NOT set new_record.
REQ-021 OVER: start SHALL go to PLAY, clear live score, streak and new_record; high_score retained.
REQ-022 score output SHALL load live score only on edges where frame_sync is high (visible the cycle after the pulse); otherwise hold, so the renderer never sees a mid-frame change.
REQ-023 frame_sync coincident with hit SHALL load the pre-increment live score; the increment appears at the next frame_sync.
REQ-024 game_over SHALL be registered, equal to (state == OVER), no combinational path from inputs.
REQ-025 high_score output SHALL update immediately (not frame-gated).

Reset
REQ-026 Reset high SHALL force state IDLE and score, high_score, live score, streak to 0, game_over and new_record to 0 on the next edge, in any state including mid-game.
REQ-027 Reset SHALL take priority over start, hit, miss and frame_sync in the same cycle.

Configuration
REQ-028 Macro STREAK_BONUS_EN defined: streak counter counts consecutive PLAY hits; the hit making streak a multiple of STREAK_LEN SHALL add 2 (saturating at MAX_SCORE); streak clears on start.
REQ-029 Macro STREAK_BONUS_EN undefined: no streak register is built; every hit adds exactly 1.

Verification
REQ-030 Reset, start, 5 hits, frame_sync -> score=5 the cycle after frame_sync, game_over=0.
REQ-031 In PLAY with live=62, 3 hits, frame_sync -> score=63 (saturated, no wrap to 0).
REQ-032 Game to 12, miss -> game_over=1, high_score=12, new_record=1; start, reach 12, miss -> high_score=12, new_record=0.
REQ-033 hit and miss together at live=7 -> OVER, high_score reflects 7, not 8.
REQ-034 Live=20 with score=20, Reset asserted mid-PLAY alongside hit -> next cycle all outputs 0, state IDLE; subsequent hit ignored.
REQ-035 STREAK_BONUS_EN defined, STREAK_LEN=8: start, 8 hits, frame_sync -> score=9; undefined -> score=8.
